// File: rtl/fpu_issuer_if.sv
// Bundle of every non-clock signal of fpu_issuer.
//   core command  : cmd_valid/cmd_ready, cmd_op, cmd_x1/x2/y, cmd_data
//   FPU port      : operation, x1/x2/y, in_data, ready -> ; <- valid, out_data1, out_data32
//   core result   : res_valid/res_ready, res_op, res_data32, res_data1, res_timeout
//   status        : busy
// master = the issuer, slave = its environment (core + FPU).
interface fpu_issuer_if;
  logic        cmd_valid, cmd_ready;
  logic [5:0]  cmd_op;
  logic [4:0]  cmd_x1, cmd_x2, cmd_y;
  logic [31:0] cmd_data;
  logic [5:0]  operation;
  logic [4:0]  x1, x2, y;
  logic [31:0] in_data;
  logic        ready, valid, out_data1;
  logic [31:0] out_data32;
  logic        res_valid, res_ready;
  logic [5:0]  res_op;
  logic [31:0] res_data32;
  logic        res_data1, res_timeout;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data,
           valid, out_data1, out_data32, res_ready,
    output cmd_ready, operation, x1, x2, y, in_data, ready,
           res_valid, res_op, res_data32, res_data1, res_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data,
           valid, out_data1, out_data32, res_ready,
    input  cmd_ready, operation, x1, x2, y, in_data, ready,
           res_valid, res_op, res_data32, res_data1, res_timeout, busy
  );
endinterface

// File: rtl/fpu_issuer.sv
// fpu_issuer: queues FPU commands from the core in a DEPTH-entry FIFO and
// issues them one at a time to the FPU ready/valid port, holding operands
// stable while ready is high. The FPU answer (or a watchdog abort after
// TIMEOUT cycles) is held on the result handshake until the core takes it.
// Ports: clk, rstn (async, active low), bus (fpu_issuer_if.master).
module fpu_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           rstn,
  fpu_issuer_if.master  bus
);
  localparam int AW        = $clog2(DEPTH);
  localparam int WW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int FULL_CNT  = DEPTH;
  localparam int WD_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  x1, x2, y;
    logic [31:0] data;
  } cmd_t;

  state_t          state, nxt;
  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop, wd_hit;
  logic [WW-1:0]   wd_cnt;

  cmd_t            cur;
  logic [5:0]      res_op;
  logic [31:0]     res_data32;
  logic            res_data1, res_timeout;

  assign full   = (count == FULL_CNT[AW:0]);
  assign empty  = (count == '0);
  assign push   = bus.cmd_valid && !full;
  // Pop only when leaving IDLE; no bypass, so a fresh command sits one cycle in the FIFO.
  assign pop    = (state == IDLE) && !empty;
  assign head   = mem[rd_ptr];
  assign wd_hit = (TIMEOUT != 0) && (wd_cnt == WD_LAST[WW-1:0]);

  // FIFO
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_op, bus.cmd_x1, bus.cmd_x2, bus.cmd_y, bus.cmd_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!empty) nxt = ISSUE;
      ISSUE:   if (bus.valid || wd_hit) nxt = RESP;
      RESP:    if (bus.res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand / result registers and watchdog
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur         <= '0;
      wd_cnt      <= '0;
      res_op      <= '0;
      res_data32  <= '0;
      res_data1   <= 1'b0;
      res_timeout <= 1'b0;
    end else if (pop) begin
      cur    <= head;
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      // valid takes priority over a watchdog expiry in the same cycle
      if (bus.valid) begin
        res_op      <= cur.op;
        res_data32  <= bus.out_data32;
        res_data1   <= bus.out_data1;
        res_timeout <= 1'b0;
      end else if (wd_hit) begin
        res_op      <= cur.op;
        res_data32  <= '0;
        res_data1   <= 1'b0;
        res_timeout <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.operation   = cur.op;
  assign bus.x1          = cur.x1;
  assign bus.x2          = cur.x2;
  assign bus.y           = cur.y;
  assign bus.in_data     = cur.data;
  // Decoded straight from the state register so reset drops ready immediately.
  assign bus.ready       = (state == ISSUE);
  assign bus.res_valid   = (state == RESP);
  assign bus.res_op      = res_op;
  assign bus.res_data32  = res_data32;
  assign bus.res_data1   = res_data1;
  assign bus.res_timeout = res_timeout;
  assign bus.busy        = (state != IDLE) || !empty;
endmodule

// File: tb/tb_fpu_issuer.sv
// Scoreboard bench for fpu_issuer with a small behavioural FPU model.
module tb_fpu_issuer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam logic [5:0] LD   = 6'b111110;
  localparam logic [5:0] FNEG = 6'b010000;
  localparam logic [5:0] ST   = 6'b111111;
  localparam logic [5:0] FEQ  = 6'b101000;
  localparam logic [5:0] HANG = 6'b000001;  // FPU model never answers this one

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fpu_issuer_if bus ();
  fpu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rstn(rstn), .bus(bus.master));

  typedef struct {
    logic [5:0]  op;
    logic [31:0] d32;
    logic        d1;
    logic        to;
    int          len;
  } sb_t;

  sb_t         sb[$];
  int          n_tests = 0, n_fail = 0;
  int          lat = 1;
  logic [31:0] ref_rf [32];
  logic [31:0] fpu_rf [32];
  int          fpu_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // FPU model: valid in the lat-th cycle of ready, result from its own register file
  always @(posedge clk) begin
    fpu_cnt <= bus.ready ? fpu_cnt + 1 : 0;
    if (bus.ready && bus.valid && (bus.operation == LD || bus.operation == FNEG))
      fpu_rf[bus.y] <= bus.out_data32;
  end
  assign bus.valid = bus.ready && (bus.operation != HANG) && (fpu_cnt == lat - 1);
  always_comb begin
    bus.out_data32 = '0;
    bus.out_data1  = 1'b0;
    case (bus.operation)
      LD:      bus.out_data32 = bus.in_data;
      FNEG:    bus.out_data32 = fpu_rf[bus.x1] ^ 32'h8000_0000;
      ST:      bus.out_data32 = fpu_rf[bus.x1];
      FEQ:     bus.out_data1  = (fpu_rf[bus.x1] == fpu_rf[bus.x2]);
      default: ;
    endcase
  end

  // Monitor: ready run length, gap, operand hold, and scoreboard compare
  int          run = 0, gap = 0, last_run = 0;
  bit          have_prev = 0;
  logic [52:0] held;
  always @(negedge clk) begin
    if (!rstn) begin
      run = 0; gap = 0; have_prev = 0;
    end else begin
      if (bus.ready) begin
        if (run == 0) begin
          if (have_prev) chk("gap_ge2", 64'(gap >= 2), 64'd1);
          held = {bus.operation, bus.x1, bus.x2, bus.y, bus.in_data};
        end else begin
          chk("operand_hold", 64'({bus.operation, bus.x1, bus.x2, bus.y, bus.in_data}), 64'(held));
        end
        run++;
        gap = 0;
      end else begin
        if (run > 0) begin last_run = run; run = 0; have_prev = 1; end
        gap++;
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
        else begin
          sb_t e;
          e = sb.pop_front();
          chk("res_op",      64'(bus.res_op),      64'(e.op));
          chk("res_data32",  64'(bus.res_data32),  64'(e.d32));
          chk("res_data1",   64'(bus.res_data1),   64'(e.d1));
          chk("res_timeout", 64'(bus.res_timeout), 64'(e.to));
          chk("ready_len",   64'(last_run),        64'(e.len));
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic push(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [31:0] data, output int waits);
    sb_t e;
    waits = 0;
    bus.cmd_op = op; bus.cmd_x1 = a; bus.cmd_x2 = b; bus.cmd_y = d; bus.cmd_data = data;
    bus.cmd_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bus.cmd_ready || waits > 200) break;
      waits++;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (waits > 200) begin
      chk("push_timeout", 64'(waits), 64'd0);
    end else begin
      e.op = op; e.d32 = '0; e.d1 = 1'b0; e.to = 1'b0; e.len = lat;
      case (op)
        LD:   begin e.d32 = data; ref_rf[d] = data; end
        FNEG: begin e.d32 = ref_rf[a] ^ 32'h8000_0000; ref_rf[d] = e.d32; end
        ST:   e.d32 = ref_rf[a];
        FEQ:  e.d1 = (ref_rf[a] == ref_rf[b]);
        HANG: begin e.to = 1'b1; e.len = TIMEOUT; end
        default: ;
      endcase
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int  w;
    bit  saw_ready, saw_res;
    rstn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_x1 = '0; bus.cmd_x2 = '0;
    bus.cmd_y = '0; bus.cmd_data = '0; bus.res_ready = 1'b0;
    #2;
    chk("rst_ready",     64'(bus.ready),       64'd0);
    chk("rst_res_valid", 64'(bus.res_valid),   64'd0);
    chk("rst_timeout",   64'(bus.res_timeout), 64'd0);
    chk("rst_busy",      64'(bus.busy),        64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready),   64'd1);
    chk("rst_operands",  64'({bus.operation, bus.x1, bus.x2, bus.y, bus.in_data}), 64'd0);
    chk("rst_results",   64'({bus.res_op, bus.res_data32, bus.res_data1}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;

    // 1: single load, FPU answers in the 3rd ready cycle
    lat = 3;
    push(LD, 5'd0, 5'd0, 5'd2, 32'hB492_46D2, w);
    drain();

    // 2: back-to-back commands, order and fneg sign flip; then compares
    lat = 2;
    push(LD,   5'd0, 5'd0, 5'd2, 32'hB492_46D2, w); chk("t2_accept0", 64'(w), 64'd0);
    push(FNEG, 5'd2, 5'd0, 5'd3, 32'h0,         w); chk("t2_accept1", 64'(w), 64'd0);
    push(ST,   5'd3, 5'd0, 5'd0, 32'h0,         w); chk("t2_accept2", 64'(w), 64'd0);
    push(LD,   5'd0, 5'd0, 5'd4, 32'hB492_46D2, w);
    push(FEQ,  5'd2, 5'd4, 5'd0, 32'h0,         w);
    push(FEQ,  5'd2, 5'd3, 5'd0, 32'h0,         w);
    drain();

    // 3: capacity DEPTH+1 with results held back
    lat = 1;
    bus.res_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(LD, 5'd0, 5'd0, 5'(10 + i), 32'h1000_0000 + 32'(i), w);
      chk("t3_accept", 64'(w), 64'd0);
    end
    bus.cmd_op = LD; bus.cmd_y = 5'd20; bus.cmd_data = 32'hDEAD_BEEF;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_full", 64'(bus.cmd_ready), 64'd0);
    end
    chk("t3_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    drain();

    // 4: watchdog abort, then a normal command behind it
    lat = 2;
    push(HANG, 5'd0, 5'd0, 5'd0, 32'h5555_5555, w);
    push(LD,   5'd0, 5'd0, 5'd5, 32'h1234_5678, w);
    drain();

    // 5: valid in the very cycle the watchdog would fire
    lat = TIMEOUT;
    push(LD, 5'd0, 5'd0, 5'd6, 32'hCAFE_F00D, w);
    drain();

    // 6: reset mid-ISSUE with two commands queued
    lat = 2;
    push(HANG, 5'd0, 5'd0, 5'd0, 32'h0, w);
    push(ST,   5'd2, 5'd0, 5'd0, 32'h0, w);
    push(ST,   5'd3, 5'd0, 5'd0, 32'h0, w);
    begin
      int n = 0;
      while (!bus.ready && n < 50) begin @(negedge clk); n++; end
    end
    chk("t6_in_issue", 64'(bus.ready), 64'd1);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("t6_ready_async", 64'(bus.ready), 64'd0);
    chk("t6_cmd_ready",   64'(bus.cmd_ready), 64'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1 chk("t6_busy", 64'(bus.busy), 64'd0);
    saw_ready = 0; saw_res = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ready)     saw_ready = 1;
      if (bus.res_valid) saw_res = 1;
    end
    chk("t6_no_stale_issue", 64'(saw_ready), 64'd0);
    chk("t6_no_result",      64'(saw_res),   64'd0);
    chk("t6_sb_empty",       64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
